usb_xfer_engine: RTL and testbench

Parametrised command/transfer engine between the GPIF2 FIFO bridge streams and the memory mux port. It parses 3-word host commands from the control-OUT stream and moves data between the data streams and memory. Unlike the fixed-width predecessor, it:
- validates every command,
- times out stalled transfers,
- returns a per-command status word on the control-IN stream (the fingerprint is sent only on a NOP ping).

---
 rtl/usb_xfer_engine_if.sv | 42 ++++
 rtl/usb_xfer_engine.sv | 158 +++++++++++++++
 tb/tb_usb_xfer_engine.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_xfer_engine_if.sv
// Stream and memory-port bundle of the USB transfer engine.
// The engine binds to the slave modport; the bridge/memory side uses master.
// ADDR_W must match the engine's ADDR_W.
interface usb_xfer_engine_if #(
  parameter int ADDR_W = 32
);
  logic [31:0]       cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [31:0]       resp_tdata;
  logic              resp_tvalid;
  logic              resp_tready;
  logic              resp_tlast;
  logic [31:0]       tx_tdata;
  logic              tx_tvalid;
  logic              tx_tready;
  logic [31:0]       rx_tdata;
  logic              rx_tvalid;
  logic              rx_tready;
  logic              rx_tlast;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wr_data;
  logic              mem_wr_ready;
  logic              mem_rd;
  logic [31:0]       mem_rd_data;
  logic              mem_rd_valid;

  modport slave (
    input  cmd_tdata, cmd_tvalid, resp_tready, tx_tdata, tx_tvalid, rx_tready,
           mem_wr_ready, mem_rd_data, mem_rd_valid,
    output cmd_tready, resp_tdata, resp_tvalid, resp_tlast, tx_tready,
           rx_tdata, rx_tvalid, rx_tlast, mem_addr, mem_wr, mem_wr_data, mem_rd
  );

  modport master (
    output cmd_tdata, cmd_tvalid, resp_tready, tx_tdata, tx_tvalid, rx_tready,
           mem_wr_ready, mem_rd_data, mem_rd_valid,
    input  cmd_tready, resp_tdata, resp_tvalid, resp_tlast, tx_tready,
           rx_tdata, rx_tvalid, rx_tlast, mem_addr, mem_wr, mem_wr_data, mem_rd
  );
endinterface

// File: rtl/usb_xfer_engine.sv
// Command/transfer engine: parses 3-word host commands, validates them,
// streams data between the host streams and memory, and answers each
// command with a status word (or the fingerprint on a NOP ping).
module usb_xfer_engine #(
  parameter int          ADDR_W      = 32,
  parameter int          LEN_W       = 32,
  parameter int          TIMEOUT     = 1000000,
  parameter logic [63:0] FINGERPRINT = 64'h47424120492F4F0A
) (
  input  logic             clk,
  input  logic             rst,
  usb_xfer_engine_if.slave bus,
  output logic             busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_XWR   = 3'd2;
  localparam logic [2:0] S_XRD   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_PING0 = 3'd5;
  localparam logic [2:0] S_PING1 = 3'd6;

  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // fingerprint halves go out byte-reversed (host reads them little-endian)
  localparam logic [31:0] PING_W0 = {FINGERPRINT[39:32], FINGERPRINT[47:40],
                                     FINGERPRINT[55:48], FINGERPRINT[63:56]};
  localparam logic [31:0] PING_W1 = {FINGERPRINT[7:0],   FINGERPRINT[15:8],
                                     FINGERPRINT[23:16], FINGERPRINT[31:24]};

  logic [2:0]        state;
  logic [1:0]        widx;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  size;
  logic [LEN_W-1:0]  offset;
  logic [15:0]       beats;
  logic [7:0]        code;
  logic [TO_W-1:0]   idle_cnt;

  logic in_wr, in_rd, beat, last_beat, timeout;

  assign in_wr     = (state == S_XWR);
  assign in_rd     = (state == S_XRD);
  assign busy      = (state != S_IDLE);
  assign last_beat = (offset == size - LEN_W'(4));

  assign bus.cmd_tready  = (state == S_IDLE);
  assign bus.mem_wr      = in_wr & bus.tx_tvalid;
  assign bus.mem_wr_data = bus.mem_wr ? bus.tx_tdata : '0;
  assign bus.tx_tready   = bus.mem_wr & bus.mem_wr_ready;
  assign bus.mem_rd      = in_rd & bus.rx_tready;
  assign bus.rx_tvalid   = bus.mem_rd & bus.mem_rd_valid;
  assign bus.rx_tdata    = bus.rx_tvalid ? bus.mem_rd_data : '0;
  assign bus.rx_tlast    = bus.rx_tvalid & last_beat;
  assign bus.mem_addr    = (bus.mem_wr | bus.mem_rd) ? base + ADDR_W'(offset) : '0;

  // a beat is a completed word on whichever side is active
  assign beat    = bus.tx_tready | bus.rx_tvalid;
  assign timeout = (TIMEOUT != 0) && !beat && (idle_cnt == TO_LAST);

  // response word mux: status in RESP, fingerprint halves in PING0/PING1
  always_comb begin
    bus.resp_tvalid = 1'b0;
    bus.resp_tlast  = 1'b0;
    bus.resp_tdata  = '0;
    case (state)
      S_RESP: begin
        bus.resp_tvalid = 1'b1;
        bus.resp_tlast  = 1'b1;
        bus.resp_tdata  = {opcode, code, beats};
      end
      S_PING0: begin
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = PING_W0;
      end
      S_PING1: begin
        bus.resp_tvalid = 1'b1;
        bus.resp_tlast  = 1'b1;
        bus.resp_tdata  = PING_W1;
      end
      default: ;
    endcase
  end

  // command capture, validation and transfer sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      widx     <= '0;
      opcode   <= '0;
      base     <= '0;
      size     <= '0;
      offset   <= '0;
      beats    <= '0;
      code     <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_tvalid) begin
          case (widx)
            2'd0:    opcode <= bus.cmd_tdata[7:0];
            2'd1:    base   <= ADDR_W'(bus.cmd_tdata);
            default: size   <= LEN_W'(bus.cmd_tdata);
          endcase
          if (widx == 2'd2) begin
            widx  <= '0;
            state <= S_CHECK;
          end else begin
            widx <= widx + 2'd1;
          end
        end
        S_CHECK: begin
          offset   <= '0;
          beats    <= '0;
          idle_cnt <= '0;
          code     <= 8'h00;
          if (opcode == 8'h00) begin
            state <= S_PING0;
          end else if (opcode != 8'h40 && opcode != 8'h80) begin
            code  <= 8'h01;
            state <= S_RESP;
          end else if (size == '0 || size[1:0] != 2'b00) begin
            code  <= 8'h02;
            state <= S_RESP;
          end else if (base[1:0] != 2'b00) begin
            code  <= 8'h03;
            state <= S_RESP;
          end else begin
            state <= (opcode == 8'h40) ? S_XRD : S_XWR;
          end
        end
        S_XWR, S_XRD: begin
          if (beat) begin
            offset   <= offset + LEN_W'(4);
            beats    <= beats + 16'd1;
            idle_cnt <= '0;
            if (last_beat) begin
              code  <= 8'h00;
              state <= S_RESP;
            end
          end else if (timeout) begin
            // undelivered host data is left in the stream on abort
            code  <= 8'h04;
            state <= S_RESP;
          end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
          end
        end
        S_RESP:  if (bus.resp_tready) state <= S_IDLE;
        S_PING0: if (bus.resp_tready) state <= S_PING1;
        S_PING1: if (bus.resp_tready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_xfer_engine.sv
// Bench for usb_xfer_engine: directed test-plan commands plus randomized
// commands and handshake patterns, checked against a command-level model.
module tb_usb_xfer_engine;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [31:0] tbmem [logic [31:0]];

  always #5 clk = ~clk;

  usb_xfer_engine_if #(.ADDR_W(32)) bus ();

  usb_xfer_engine #(.ADDR_W(32), .LEN_W(32), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // memory read contents are a fixed function of the address
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  assign bus.mem_rd_data = pat(bus.mem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.cmd_tvalid   = 1'b0;
    bus.cmd_tdata    = '0;
    bus.resp_tready  = 1'b0;
    bus.tx_tvalid    = 1'b0;
    bus.tx_tdata     = '0;
    bus.rx_tready    = 1'b0;
    bus.mem_wr_ready = 1'b0;
    bus.mem_rd_valid = 1'b0;
  endtask

  // mode 0: mostly-ready random, 1: always ready, 2: toggle every cycle
  function automatic logic rdy(input int mode, input int c);
    case (mode)
      1:       return 1'b1;
      2:       return c[0];
      default: return ($urandom_range(7) != 0);
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {bus.cmd_tready, busy, bus.resp_tvalid, bus.resp_tlast, bus.mem_wr,
                        bus.mem_rd, bus.tx_tready, bus.rx_tvalid, bus.rx_tlast}, 9'b1_0000_0000);
    chk({tag, "_rdata"}, bus.resp_tdata, 64'd0);
  endtask

  // issue one command, run it to its last response word, and check it
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] size,
                         input int supply, input int mode, input int rst_at);
    logic [31:0] w [3];
    logic [31:0] txw [$];
    logic [31:0] rsp [$];
    logic        rlast [$];
    logic [31:0] a, pdata;
    logic        pend, is_ping, is_err, is_wr;
    int idx, n, nwr, nrx, ntx, nreq, zero_v, stab_v, busy_v, hs_v;
    int n_cyc, first_req, first_resp, last_b, exp_nrsp, exp_code, exp_beats;

    // reference model: outcome of the command from its fields alone
    n        = int'(size >> 2);
    is_ping  = (op == 8'h00);
    is_err   = 1'b0;
    exp_code = 0;
    if (is_ping) exp_code = 0;
    else if (op != 8'h40 && op != 8'h80) begin exp_code = 1; is_err = 1'b1; end
    else if (size == 0 || size[1:0] != 2'b00) begin exp_code = 2; is_err = 1'b1; end
    else if (addr[1:0] != 2'b00) begin exp_code = 3; is_err = 1'b1; end
    else if (op == 8'h80 && supply < n) exp_code = 4;
    exp_beats = is_err ? 0 : ((exp_code == 4) ? supply : n);
    is_wr     = (op == 8'h80) && !is_err;
    exp_nrsp  = is_ping ? 2 : 1;
    for (int k = 0; k < n; k++) txw.push_back((mode == 2) ? 32'h8C + 32'(k) : $urandom);
    tbmem.delete();
    w[0] = {24'($urandom), op};
    w[1] = addr;
    w[2] = size;

    idx = 0;
    n_cyc = -1;
    for (int t = 0; t < 200 && n_cyc < 0; t++) begin
      @(negedge clk); cyc++;
      idle_in();
      bus.cmd_tvalid = (mode == 0) ? ($urandom_range(3) != 0) : 1'b1;
      bus.cmd_tdata  = bus.cmd_tvalid ? w[idx] : $urandom;
      #2;
      if (bus.cmd_tvalid && bus.cmd_tready) begin
        idx++;
        if (idx == 3) n_cyc = cyc;
      end
    end
    chk("cmd_accept", n_cyc >= 0, 1);
    if (n_cyc < 0) return;

    nwr = 0; nrx = 0; ntx = 0; nreq = 0; zero_v = 0; stab_v = 0; busy_v = 0; hs_v = 0;
    first_req = -1; first_resp = -1; last_b = -1; pend = 1'b0; pdata = '0;
    for (int t = 0; t < 3000 && rsp.size() < exp_nrsp; t++) begin
      @(negedge clk); cyc++;
      if (t == rst_at) begin
        idle_in();
        bus.rx_tready    = 1'b1;
        bus.mem_rd_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk); cyc++; #2;
        chk_reset_vals("rst_mid");
        chk("rst_mid_had_beats", nrx > 0, 1);
        rst = 1'b0;
        return;
      end
      bus.cmd_tvalid   = 1'($urandom_range(1));
      bus.cmd_tdata    = $urandom;
      bus.tx_tvalid    = (ntx < supply && ntx < n) ? ((mode == 0) ? rdy(0, cyc) : 1'b1) : 1'b0;
      bus.tx_tdata     = bus.tx_tvalid ? txw[ntx] : $urandom;
      bus.mem_wr_ready = rdy(mode, cyc);
      bus.rx_tready    = rdy(mode, cyc);
      bus.mem_rd_valid = (mode == 0) ? rdy(0, cyc) : 1'b1;
      bus.resp_tready  = (mode == 0) ? 1'($urandom_range(1)) : rdy(mode, cyc);
      #2;
      if (bus.mem_wr || bus.mem_rd) begin
        nreq++;
        if (first_req < 0) first_req = cyc;
      end
      if (!bus.mem_wr && bus.mem_wr_data != 0) zero_v++;
      if (!bus.rx_tvalid && (bus.rx_tdata != 0 || bus.rx_tlast)) zero_v++;
      if (!bus.resp_tvalid && bus.resp_tdata != 0) zero_v++;
      if (bus.cmd_tready || !busy) busy_v++;
      if ((bus.mem_wr && bus.mem_wr_ready) != (bus.tx_tvalid && bus.tx_tready)) hs_v++;
      if (bus.mem_wr && bus.mem_wr_ready) begin
        tbmem[bus.mem_addr] = bus.mem_wr_data;
        nwr++;
      end
      if (bus.tx_tvalid && bus.tx_tready) begin
        ntx++;
        last_b = cyc;
      end
      if (bus.rx_tvalid && bus.rx_tready) begin
        chk("rx_data", bus.rx_tdata, pat(addr + 32'(4 * nrx)));
        chk("rx_last", bus.rx_tlast, nrx == n - 1);
        nrx++;
        last_b = cyc;
      end
      if (pend && (!bus.resp_tvalid || bus.resp_tdata != pdata)) stab_v++;
      if (bus.resp_tvalid && first_resp < 0) first_resp = cyc;
      pend  = bus.resp_tvalid && !bus.resp_tready;
      pdata = bus.resp_tdata;
      if (bus.resp_tvalid && bus.resp_tready) begin
        rsp.push_back(bus.resp_tdata);
        rlast.push_back(bus.resp_tlast);
      end
    end

    chk("resp_cnt", rsp.size(), exp_nrsp);
    if (rsp.size() == exp_nrsp) begin
      if (is_ping) begin
        chk("ping_w0", rsp[0], 32'h20414247);
        chk("ping_l0", rlast[0], 0);
        chk("ping_w1", rsp[1], 32'h0A4F2F49);
        chk("ping_l1", rlast[1], 1);
      end else begin
        chk("resp_word", rsp[0], {op, 8'(exp_code), 16'(exp_beats)});
        chk("resp_last", rlast[0], 1);
      end
    end
    chk("busy_ignore", busy_v, 0);
    chk("zero_when_idle", zero_v, 0);
    chk("resp_stable", stab_v, 0);
    chk("tx_handshake", hs_v, 0);
    if (is_ping || is_err) begin
      chk("no_mem", nreq, 0);
      chk("resp_latency", first_resp, n_cyc + 2);
    end else begin
      if (is_wr) begin
        chk("wr_cnt", nwr, exp_beats);
        chk("wr_span", tbmem.size(), exp_beats);
        for (int k = 0; k < exp_beats; k++) begin
          a = addr + 32'(4 * k);
          chk("wr_present", tbmem.exists(a), 1);
          if (tbmem.exists(a)) chk("wr_data", tbmem[a], txw[k]);
        end
      end else begin
        chk("rd_cnt", nrx, n);
      end
      if (exp_code == 4)
        chk("timeout_latency", first_resp, (supply > 0) ? last_b + TO + 1 : n_cyc + 2 + TO);
      else
        chk("done_latency", first_resp, last_b + 1);
      if (mode == 1 && supply > 0) chk("req_latency", first_req, n_cyc + 2);
    end

    @(negedge clk); cyc++;
    idle_in();
    #2;
    chk("idle_again", {bus.cmd_tready, busy}, 2'b10);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] addr, size;
    int r;
    idle_in();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_vals("reset");
    rst = 1'b0;

    run_cmd(8'h00, 32'h0,         0,  0,  1, -1);  // ping
    run_cmd(8'h80, 32'h100,       16, 99, 2, -1);  // write, memory stalls
    run_cmd(8'h40, 32'h100,       16, 99, 2, -1);  // read, rx_tready toggles
    run_cmd(8'h12, 32'h100,       16, 99, 1, -1);  // bad opcode
    run_cmd(8'h80, 32'h100,       6,  99, 1, -1);  // unaligned size
    run_cmd(8'h40, 32'h102,       16, 99, 1, -1);  // unaligned addr
    run_cmd(8'h80, 32'h100,       0,  99, 1, -1);  // zero size
    run_cmd(8'h40, 32'h200,       4,  99, 1, -1);  // single beat
    run_cmd(8'h80, 32'h180,       12, 99, 1, -1);  // back-to-back write
    run_cmd(8'h80, 32'hFFFF_FFF8, 16, 99, 0, -1);  // address wrap
    run_cmd(8'h80, 32'h300,       8,  1,  1, -1);  // timeout after one beat
    run_cmd(8'h00, 32'h0,         0,  0,  0, -1);  // ping after timeout
    run_cmd(8'h80, 32'h400,       8,  0,  1, -1);  // timeout with no beats
    run_cmd(8'h40, 32'h500,       64, 99, 1, 6);   // reset mid-read
    run_cmd(8'h40, 32'h500,       16, 99, 1, -1);  // recovers after reset

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(9);
      if (r == 0)      op = 8'h00;
      else if (r == 1) op = 8'($urandom);
      else             op = (r < 6) ? 8'h40 : 8'h80;
      addr = $urandom;
      if ($urandom_range(7) != 0) addr[1:0] = 2'b00;
      size = ($urandom_range(7) != 0) ? 32'(4 * $urandom_range(1, 12)) : 32'($urandom_range(0, 7));
      run_cmd(op, addr, size, 99, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
